// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Purpose:
//   Instruction-phase sequencer for a simple multi-cycle CPU. Each instruction
//   takes eight enabled cycles (phase 0..7). The sequencer can run
//   continuously, single-step one instruction, stop cleanly at an instruction
//   boundary, or halt mid-instruction on request from the controller.
//
// Ports:
//   clk         in   rising-edge clock for all state
//   rst_        in   synchronous, active-low reset
//   run         in   start/resume continuous execution (level)
//   step        in   execute exactly one instruction (level)
//   stop        in   stop at the next instruction boundary (latched in RUN)
//   halt        in   halt request from the controller (phase 4 of HLT)
//   phase       out  current instruction phase (0..7)
//   cpu_en      out  datapath register enable, 1 only in RUN or STEP
//   halted      out  1 while in HALT
//   instr_done  out  one-cycle pulse during the phase-7 cycle
//   instr_count out  saturating completed-instruction counter
//                    (present only when SEQ_INSTR_COUNT_EN is defined)
//
// Configuration:
//   SEQ_INSTR_COUNT_EN  define to add the instr_count port and its counter.
//   CNT_WIDTH           width of instr_count (default 16).
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 run,
  input  logic                 step,
  input  logic                 stop,
  input  logic                 halt,
  output logic [2:0]           phase,
  output logic                 cpu_en,
  output logic                 halted,
  output logic                 instr_done
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t state;
  logic   stop_latch;
  logic   completing;

  // Reject a zero-width counter at elaboration time.
  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("cpu_sequencer: CNT_WIDTH must be at least 1");
  end

  // The edge that moves an active instruction from phase 6 into phase 7.
  // Because outputs are registered, instr_done (and the counter) are loaded
  // on this edge so they are visible during the phase-7 cycle. A halt on
  // this edge kills the instruction, so no completion is recorded.
  always_comb begin
    completing = 1'b0;
    if ((state == RUN || state == STEP) && !halt && phase == 3'd6) begin
      completing = 1'b1;
    end
  end

  // Main sequencer FSM. Every output is a register written here so the
  // controller sees glitch-free phase/enable values.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state      <= IDLE;
      phase      <= 3'd0;
      cpu_en     <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      stop_latch <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        // IDLE and HALT share start rules; halt is ignored in both.
        IDLE, HALT: begin
          if (run || step) begin
            state  <= run ? RUN : STEP;
            phase  <= 3'd0;
            cpu_en <= 1'b1;
            halted <= 1'b0;
          end
        end

        RUN, STEP: begin
          if (halt) begin
            // Halt wins over a pending stop and over step completion; the
            // stop latch is dropped so a later resume is not cut short.
            state      <= HALT;
            phase      <= 3'd0;
            cpu_en     <= 1'b0;
            halted     <= 1'b1;
            stop_latch <= 1'b0;
          end else if (phase == 3'd7 &&
                       (state == STEP || stop_latch || stop)) begin
            state      <= IDLE;
            phase      <= 3'd0;
            cpu_en     <= 1'b0;
            stop_latch <= 1'b0;
          end else begin
            phase      <= phase + 3'd1;
            instr_done <= completing;
            if (state == RUN && stop) begin
              stop_latch <= 1'b1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          phase      <= 3'd0;
          cpu_en     <= 1'b0;
          halted     <= 1'b0;
          stop_latch <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  // Completed-instruction counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      instr_count <= '0;
    end else if (completing && instr_count != '1) begin
      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Purpose:
//   Directed self-checking bench for cpu_sequencer. Walks through reset,
//   continuous run, stop at an instruction boundary, single step, halt with a
//   simultaneous stop, resume from halt, reset mid-instruction and halt at the
//   end of a step. With SEQ_INSTR_COUNT_EN defined the saturating
//   instruction counter (CNT_WIDTH=2) is also checked.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_;
  logic       run;
  logic       step;
  logic       stop;
  logic       halt;
  logic [2:0] phase;
  logic       cpu_en;
  logic       halted;
  logic       instr_done;
`ifdef SEQ_INSTR_COUNT_EN
  logic [1:0] instr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CNT_WIDTH (2)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .run        (run),
    .step       (step),
    .stop       (stop),
    .halt       (halt),
    .phase      (phase),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .instr_done (instr_done)
`ifdef SEQ_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s,
                               input logic st, input logic h);
    run  = r;
    step = s;
    stop = st;
    halt = h;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_phase,
                             input logic exp_en, input logic exp_halted,
                             input logic exp_done);
    n_checks++;
    assert ({phase, cpu_en, halted, instr_done} ===
            {exp_phase, exp_en, exp_halted, exp_done})
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got phase=%0d cpu_en=%b halted=%b instr_done=%b, want phase=%0d cpu_en=%b halted=%b instr_done=%b",
             tag, phase, cpu_en, halted, instr_done,
             exp_phase, exp_en, exp_halted, exp_done);
    end
  endtask

`ifdef SEQ_INSTR_COUNT_EN
  task automatic checkCount(input string tag, input logic [1:0] exp_count);
    n_checks++;
    assert (instr_count === exp_count)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got instr_count=%0d, want %0d",
             tag, instr_count, exp_count);
    end
  endtask
`endif

  initial begin
    rst_ = 1'b0;
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset", 3'd0, 0, 0, 0);
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("reset_count", 2'd0);
`endif

    // Reset beats run.
    applyStimulus(1, 0, 0, 0);
    tick();
    checkOutput("reset_over_run", 3'd0, 0, 0, 0);

    // First clock out of reset takes the IDLE->RUN transition.
    $display("[TB] continuous run");
    rst_ = 1'b1;
    tick();
    checkOutput("run_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput($sformatf("run_c%0d", i), 3'(i % 8), 1, 0, (i % 8) == 7);
`ifdef SEQ_INSTR_COUNT_EN
      if (i == 7)  checkCount("count_1", 2'd1);
      if (i == 15) checkCount("count_2", 2'd2);
`endif
      // run/step while running must be ignored.
      if (i == 3) applyStimulus(1, 1, 0, 0);
      else        applyStimulus(0, 0, 0, 0);
    end

    // Stop requested during phase 2 finishes the instruction then idles.
    $display("[TB] stop at boundary");
    tick();
    checkOutput("stop_p0", 3'd0, 1, 0, 0);
    tick();
    checkOutput("stop_p1", 3'd1, 1, 0, 0);
    tick();
    checkOutput("stop_p2", 3'd2, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    tick();
    checkOutput("stop_p3", 3'd3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 4; p < 8; p++) begin
      tick();
      checkOutput($sformatf("stop_p%0d", p), 3'(p), 1, 0, p == 7);
    end
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("count_3", 2'd3);
`endif
    tick();
    checkOutput("stop_idle", 3'd0, 0, 0, 0);
    tick();
    tick();
    checkOutput("stop_idle_hold", 3'd0, 0, 0, 0);

    // Single step; run/step/stop mid-step are ignored.
    $display("[TB] single step");
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("step_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 1; p < 8; p++) begin
      tick();
      checkOutput($sformatf("step_p%0d", p), 3'(p), 1, 0, p == 7);
      if (p == 3) applyStimulus(1, 1, 1, 0);
      else        applyStimulus(0, 0, 0, 0);
    end
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("count_sat_step", 2'd3);
`endif
    tick();
    checkOutput("step_idle", 3'd0, 0, 0, 0);

    // Halt is ignored in IDLE.
    applyStimulus(0, 0, 0, 1);
    tick();
    checkOutput("halt_in_idle", 3'd0, 0, 0, 0);

    // Halt together with stop at phase 4: HALT wins, no instr_done.
    $display("[TB] halt with stop");
    applyStimulus(1, 0, 0, 0);
    tick();
    checkOutput("halt_run_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 1; p < 5; p++) begin
      tick();
      checkOutput($sformatf("halt_run_p%0d", p), 3'(p), 1, 0, 0);
    end
    applyStimulus(0, 0, 1, 1);
    tick();
    checkOutput("halt_enter", 3'd0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    tick();
    checkOutput("halt_hold", 3'd0, 0, 1, 0);

    // Resume from HALT starts again at phase 0 and runs past phase 7.
    applyStimulus(1, 0, 0, 0);
    tick();
    checkOutput("resume_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 1; p < 8; p++) begin
      tick();
      checkOutput($sformatf("resume_p%0d", p), 3'(p), 1, 0, p == 7);
    end
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("count_sat_resume", 2'd3);
`endif
    tick();
    checkOutput("resume_wrap", 3'd0, 1, 0, 0);

    // Reset at phase 5 with every input asserted.
    $display("[TB] reset mid-instruction");
    for (int p = 1; p < 6; p++) begin
      tick();
      checkOutput($sformatf("pre_rst_p%0d", p), 3'(p), 1, 0, 0);
    end
    rst_ = 1'b0;
    applyStimulus(1, 1, 1, 1);
    tick();
    checkOutput("mid_reset", 3'd0, 0, 0, 0);
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("mid_reset_count", 2'd0);
`endif
    rst_ = 1'b1;
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("post_reset_idle", 3'd0, 0, 0, 0);

    // Halt during the last phase of a step beats step completion.
    $display("[TB] halt at end of step");
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("hstep_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 1; p < 8; p++) begin
      tick();
      checkOutput($sformatf("hstep_p%0d", p), 3'(p), 1, 0, p == 7);
    end
    applyStimulus(0, 0, 0, 1);
    tick();
    checkOutput("hstep_halt", 3'd0, 0, 1, 0);
`ifdef SEQ_INSTR_COUNT_EN
    checkCount("hstep_count", 2'd1);
`endif

    // Step out of HALT.
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("halt_step_p0", 3'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int p = 1; p < 8; p++) begin
      tick();
    end
    checkOutput("halt_step_p7", 3'd7, 1, 0, 1);
    tick();
    checkOutput("halt_step_idle", 3'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: CNT_WIDTH, default 16, width of the instruction counter (REQ-031).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_  input  1  reset, synchronous, active-low.
REQ-004 Port: run  input  1  start/resume continuous execution; level sampled each clock.
REQ-005 Port: step  input  1  execute exactly one instruction; level sampled each clock.
REQ-006 Port: stop  input  1  request to stop at the next instruction boundary.
REQ-007 Port: halt  input  1  halt request from the controller, asserted during phase 4 of HLT.
REQ-008 Port: phase  output  3  instruction phase driven to the controller.
REQ-009 Port: cpu_en  output  1  datapath register enable; 1 only in RUN or STEP.
REQ-010 Port: halted  output  1  1 while in HALT.
REQ-011 Port: instr_done  output  1  one-cycle pulse marking completion of an instruction.

Function
REQ-012 The block SHALL implement four states: IDLE, RUN, STEP, HALT; all outputs registered.
REQ-013 In IDLE, phase SHALL hold at 0 and cpu_en SHALL be 0.
REQ-014 IDLE: run=1 SHALL enter RUN; step=1 with run=0 SHALL enter STEP; run has priority when both are 1.
REQ-015 In RUN and STEP, phase SHALL increment by 1 each clock, wrapping from 7 to 0.
REQ-016 instr_done SHALL be 1 exactly during the cycle in which phase=7 and state is RUN or STEP.
REQ-017 The first active cycle after entering RUN or STEP SHALL present phase=0.
REQ-018 RUN: stop=1 SHALL be latched, and the block SHALL enter IDLE after the phase=7 cycle; the latch SHALL clear on entering IDLE.
REQ-019 RUN: run or step asserted SHALL be ignored.
REQ-020 STEP SHALL run phases 0..7 once, then enter IDLE; run, step and stop SHALL be ignored during STEP.
REQ-021 halt=1 sampled in RUN or STEP SHALL enter HALT on the next clock, with phase forced to 0 and cpu_en=0.
REQ-022 halt SHALL take priority over a pending or simultaneous stop and over STEP completion.
REQ-023 halt SHALL be ignored in IDLE and HALT.
REQ-024 HALT: halted=1, phase=0, cpu_en=0; run=1 SHALL enter RUN; step=1 with run=0 SHALL enter STEP.
REQ-025 instr_done SHALL NOT pulse for an instruction terminated by halt.
REQ-026 Exactly 8 enabled cycles SHALL elapse per completed instruction; no idle cycles between instructions in RUN.

Reset
REQ-027 rst_=0 at a rising clk edge SHALL force state IDLE, phase=0, cpu_en=0, halted=0, instr_done=0, stop latch=0.
REQ-028 Reset SHALL take priority over every input, including mid-instruction, and SHALL be sampled only on the clk edge.
REQ-029 The first clock with rst_=1 SHALL evaluate IDLE transition rules normally.

Configuration
REQ-030 The feature SHALL be controlled by the macro SEQ_INSTR_COUNT_EN.
REQ-031 With SEQ_INSTR_COUNT_EN defined: port instr_count (output, CNT_WIDTH); increments by 1 on each instr_done; saturates at all-ones; cleared only by reset.
REQ-032 Without SEQ_INSTR_COUNT_EN: port instr_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset then run=1 for 1 cycle -> phase 0,1,...,7,0,... with cpu_en=1; instr_done high exactly when phase=7.
REQ-034 From IDLE, step=1 for 1 cycle -> 8 cycles, phases 0..7, one instr_done, then IDLE with phase=0 and cpu_en=0.
REQ-035 RUN, stop=1 at phase 2 -> phases continue to 7, instr_done pulses, then IDLE; no further phase advance.
REQ-036 RUN, halt=1 at phase 4 together with stop=1 -> next cycle HALT, halted=1, phase=0, no instr_done; then run=1 -> RUN from phase 0.
REQ-037 rst_=0 at phase 5 in RUN -> next cycle IDLE, all outputs 0; with SEQ_INSTR_COUNT_EN, instr_count=0.
REQ-038 With SEQ_INSTR_COUNT_EN and CNT_WIDTH=2, 5 completed instructions -> instr_count sequence 1,2,3,3,3.
